// File: rtl/hazard_forward_ctrl.sv
// Register-hazard controller for a 5-stage pipeline: load-use stall, registered
// EX forwarding selects and a saturating stall-cycle counter.
module hazard_forward_ctrl #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Only tag bits that influence a decision are held. The WB tag and the MEM
    // load flag never do: the regfile writes before it is read, and a load in
    // MEM forwards exactly like any other producer.
    logic              r_ex_v;
    logic [ADDR_W-1:0] r_ex_rd;
    logic              r_ex_rw;
    logic              r_ex_mr;
    logic              r_mem_v;
    logic [ADDR_W-1:0] r_mem_rd;
    logic              r_mem_rw;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [ADDR_W-1:0] w_src [2];
    logic [1:0]        w_use;
    logic [1:0]        w_hit_ex;
    logic [1:0]        w_hit_mem;
    logic [1:0]        w_fwd_next [2];
    logic              w_lu;

    assign w_src[0] = id_rs;
    assign w_src[1] = id_rt;
    assign w_use    = {id_uses_rt, id_uses_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            assign w_hit_ex[gi]  = w_use[gi] & r_ex_v & r_ex_rw &
                                   (r_ex_rd != '0) & (w_src[gi] == r_ex_rd);
            assign w_hit_mem[gi] = w_use[gi] & r_mem_v & r_mem_rw &
                                   (r_mem_rd != '0) & (w_src[gi] == r_mem_rd);
            // Younger producer (now in EX, about to be in MEM) takes priority.
            assign w_fwd_next[gi] = !id_valid     ? 2'b00 :
                                    w_hit_ex[gi]  ? 2'b01 :
                                    w_hit_mem[gi] ? 2'b10 : 2'b00;
        end
    endgenerate

    assign w_lu  = id_valid & ~flush & r_ex_mr & (|w_hit_ex);
    assign stall = mem_busy | w_lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v      <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_mem_v     <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_rw    <= 1'b0;
            r_fwd_a     <= 2'b00;
            r_fwd_b     <= 2'b00;
            r_stall_cnt <= '0;
        end else if (!mem_busy) begin
            r_mem_v  <= r_ex_v;
            r_mem_rd <= r_ex_rd;
            r_mem_rw <= r_ex_rw;
            if (w_lu || flush) begin
                // Bubble into EX; remaining EX fields are don't-care once v = 0.
                r_ex_v  <= 1'b0;
                r_fwd_a <= 2'b00;
                r_fwd_b <= 2'b00;
                if (w_lu && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end else begin
                r_ex_v  <= id_valid;
                r_ex_rd <= id_rd;
                r_ex_rw <= id_regwrite;
                r_ex_mr <= id_memread;
                r_fwd_a <= w_fwd_next[0];
                r_fwd_b <= w_fwd_next[1];
            end
        end
    end

    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomized scoreboard bench for hazard_forward_ctrl against an in-flight
// instruction list model.
module tb_hazard_forward_ctrl;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;
    localparam int NCYC   = 600;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [ADDR_W-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic              mem_busy;
    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    hazard_forward_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .mem_busy(mem_busy), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        bit [4:0]   rd;
        bit         rw;
        bit         ld;
    } instr_t;

    typedef struct {
        int         cyc;
        bit         stall;
        bit [1:0]   fa;
        bit [1:0]   fb;
        bit [15:0]  cnt;
    } exp_t;

    // flight[0] is the instruction in EX, flight[1] the one in MEM.
    instr_t    flight[$];
    exp_t      sb[$];
    bit [1:0]  m_fa, m_fb;
    bit [15:0] m_cnt;
    int        checks = 0;
    int        failures = 0;

    // Distance back to the youngest in-flight writer of r (1 = EX, 2 = MEM, 0 = none).
    function automatic int producer_dist(bit [4:0] r);
        for (int i = 0; i < 2; i++) begin
            if (flight[i].v && flight[i].rw && flight[i].rd != 0 && flight[i].rd == r)
                return i + 1;
        end
        return 0;
    endfunction

    function automatic bit [1:0] sel_of(bit valid, bit uses, int d);
        if (!valid || !uses) return 2'b00;
        if (d == 1) return 2'b01;
        if (d == 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        instr_t b = '{v: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0};
        flight.delete();
        flight.push_back(b);
        flight.push_back(b);
        m_fa  = 2'b00;
        m_fb  = 2'b00;
        m_cnt = 16'd0;
    endtask

    task automatic check(string name, int cyc, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Monitor: one transaction per cycle, compared away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("txn cyc=%0d stall=%0b fwd_a=%0d fwd_b=%0d cnt=%0d",
                         e.cyc, stall, fwd_a, fwd_b, stall_cnt);
                check("stall", e.cyc, int'(stall), int'(e.stall));
                check("fwd_a", e.cyc, int'(fwd_a), int'(e.fa));
                check("fwd_b", e.cyc, int'(fwd_b), int'(e.fb));
                check("stall_cnt", e.cyc, int'(stall_cnt), int'(e.cnt));
            end
        end
    end

    initial begin
        int     busy_left = 0;
        int     d_rs, d_rt;
        bit     lu_m;
        exp_t   e;
        instr_t nw;

        rst_n = 1'b0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0;
        id_uses_rt = 0; id_rd = 0; id_regwrite = 0; id_memread = 0;
        flush = 0; mem_busy = 0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            rst_n = !(cyc < 3 || cyc == 300 || cyc == 301);
            id_valid    = ($urandom_range(0, 9) != 0);
            id_rs       = ADDR_W'($urandom_range(0, 3));
            id_rt       = ADDR_W'($urandom_range(0, 3));
            id_uses_rs  = ($urandom_range(0, 4) != 0);
            id_uses_rt  = ($urandom_range(0, 4) != 0);
            id_rd       = ADDR_W'($urandom_range(0, 3));
            id_regwrite = ($urandom_range(0, 4) != 0);
            id_memread  = ($urandom_range(0, 2) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            if (busy_left > 0) begin
                busy_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                busy_left = $urandom_range(1, 4);
            end
            mem_busy = rst_n && (busy_left > 0);

            if (!rst_n) model_reset();

            d_rs = producer_dist(id_rs);
            d_rt = producer_dist(id_rt);
            lu_m = id_valid && !flush &&
                   ((id_uses_rs && d_rs == 1 && flight[0].ld) ||
                    (id_uses_rt && d_rt == 1 && flight[0].ld));

            e.cyc   = cyc;
            e.stall = mem_busy || lu_m;
            e.fa    = m_fa;
            e.fb    = m_fb;
            e.cnt   = m_cnt;
            sb.push_back(e);

            if (rst_n && !mem_busy) begin
                if (lu_m || flush) begin
                    nw = '{v: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0};
                    m_fa = 2'b00;
                    m_fb = 2'b00;
                    if (lu_m && m_cnt != 16'hFFFF) m_cnt++;
                end else begin
                    nw = '{v: id_valid, rd: id_rd, rw: id_regwrite, ld: id_memread};
                    m_fa = sel_of(id_valid, id_uses_rs, d_rs);
                    m_fb = sel_of(id_valid, id_uses_rt, d_rt);
                end
                flight.push_front(nw);
                void'(flight.pop_back());
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", NCYC, sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Register-hazard controller for the 5-stage pipeline, consuming the 5-bit register-address equality function that sits directly upstream of it.
- Keeps a shadow pipeline of destination-register tags for the EX, MEM and WB stages.
- Issues the load-use stall to IF/ID.
- Produces registered forwarding selects for the EX operand muxes, and counts stall cycles for performance monitoring.

Parameters:
- ADDR_W, 5, register address width; register 0 is hardwired zero and never forms a hazard.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  ADDR_W  ID source register A.
- id_rt  input  ADDR_W  ID source register B.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_rd  input  ADDR_W  ID destination register.
- id_regwrite  input  1  instruction writes id_rd.
- id_memread  input  1  instruction is a load.
- flush  input  1  branch taken in EX; kills the ID instruction this cycle.
- mem_busy  input  1  data memory not ready; freezes the whole pipeline.
- stall  output  1  hold PC and IF/ID, inject bubble into EX (combinational).
- fwd_a  output  2  EX operand A select: 00 regfile, 01 from MEM result, 10 from WB result (registered).
- fwd_b  output  2  same encoding for operand B (registered).
- stall_cnt  output  CNT_W  load-use stall cycles since reset, saturating.

Behaviour:
- State:
  - EX entry {v, rd, regwrite, memread}.
  - MEM entry {v, rd, regwrite, memread}.
  - WB entry {v, rd, regwrite}.
  - fwd_a, fwd_b, stall_cnt.
- Reset (rst_n low, async): all entry v = 0, fwd_a = fwd_b = 00, stall_cnt = 0. stall is therefore 0 during and after reset.
- Match function: match(x, e) = e.v & e.regwrite & (e.rd != 0) & (x == e.rd).
- Load-use hazard:
  - lu = id_valid & !flush & EX.memread & ((id_uses_rs & match(id_rs, EX)) | (id_uses_rt & match(id_rt, EX))).
  - stall = mem_busy | lu.
- Cycle update, priority order:
  1. Freeze, if mem_busy: all entries, fwd_a/fwd_b and stall_cnt hold. flush is ignored; its source must hold it until mem_busy drops.
  2. Bubble, else if lu:
     - EX <= bubble (v = 0); MEM <= EX; WB <= MEM.
     - fwd_a/fwd_b <= 00.
     - stall_cnt += 1 unless all-ones.
  3. Flush, else if flush: EX <= bubble, MEM <= EX, WB <= MEM, fwd <= 00.
  4. Advance, else: EX <= {id_valid, id_rd, id_regwrite, id_memread}, MEM <= EX, WB <= MEM.
     - fwd_a <= 01 if id_uses_rs & match(id_rs, EX);
     - else 10 if id_uses_rs & match(id_rs, MEM);
     - else 00. fwd_b likewise with id_rt.
     - The younger producer (current EX, becoming MEM) always wins over the older.
     - An id_valid = 0 instruction yields fwd = 00.
- Latency:
  - stall responds in the same cycle as the ID inputs.
  - fwd_a/fwd_b are valid in the cycle the instruction occupies EX, one clock after it was in ID.
- A load in EX never produces fwd = 01 for a consumer: that case is always lu, and after the one-cycle bubble the load is in MEM, giving 10.
- Regfile write-before-read: a WB-stage producer needs no forwarding for the instruction in ID.
- rst_n asserted mid-stall or mid-freeze clears everything immediately; the first cycle after release behaves as an empty pipeline.
- Simultaneous flush and lu: flush wins, no stall and no count increment.

Test Plan:
- Back-to-back ALU ops: add r3 in ID, then sub reading rs = r3 the next cycle -> fwd_a = 01 in the consumer's EX cycle, stall = 0. With one independent instruction between them -> fwd_a = 10.
- Load-use: lw r5 followed by add using rt = r5 -> stall = 1 for exactly one cycle, EX bubble, stall_cnt 0 -> 1, then fwd_b = 10.
- Register 0 and unused operands: producer rd = 0, consumer rs = 0 -> fwd_a = 00, no stall. lw r5 with consumer id_uses_rt = 0 and rt = 5 -> no stall.
- Double producer: r7 written in EX and in MEM, consumer reads r7 on both operands -> fwd_a = fwd_b = 01.
- mem_busy held 3 cycles during a pending load-use -> stall = 1 for all 3, entries and stall_cnt frozen. On release the load-use stall occurs once and stall_cnt increments by 1 only.
- flush with a concurrent load-use condition -> stall = 0, EX bubble, stall_cnt unchanged. Async rst_n pulse mid-sequence -> fwd = 00 and stall_cnt = 0 immediately.
